// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline stage: a DEPTH-entry circular FIFO with registered-only
// handshake outputs, synchronous flush and a saturating downstream-idle counter.
module pipe_elastic_reg #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic [15:0]      bubble_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [15:0]      bubble_q, bubble_d;
    logic             push, pop, wr_en;

    // Handshake outputs come from registered state only, never from out_ready.
    assign in_ready   = (count_q < CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
    assign count      = count_q;
    assign bubble_cnt = bubble_q;

    assign push  = in_valid & in_ready;
    assign pop   = out_valid & out_ready;
    assign wr_en = push & ~flush;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bubble_d = bubble_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // Flush does not clear the idle counter; it only suppresses counting.
        if (out_ready && !out_valid && !flush && bubble_q != 16'hFFFF)
            bubble_d = bubble_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    // Payload storage is deliberately left unreset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Self-checking bench for pipe_elastic_reg: DEPTH=2 and DEPTH=3 instances share
// stimulus and are compared against queue-based reference models.
module tb_pipe_elastic_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic        in_ready2, out_valid2, in_ready3, out_valid3;
    logic [7:0]  out_data2, out_data3;
    logic [1:0]  count2, count3;
    logic [15:0] bubble2, bubble3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mq2[$];
    logic [7:0]  mq3[$];
    logic [15:0] mb2, mb3;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic [1:0]  cnt;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic [15:0] bub;
    } vec_t;

    vec_t vecs[12];

    pipe_elastic_reg #(.WIDTH(8), .DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
        .count(count2), .bubble_cnt(bubble2)
    );

    pipe_elastic_reg #(.WIDTH(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready),
        .count(count3), .bubble_cnt(bubble3)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq2.delete();
        mq3.delete();
        mb2 = '0;
        mb3 = '0;
    endtask

    // Reference behaviour of one clock edge, from the state before that edge.
    task automatic modelStep(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        bit pu2, po2, pu3, po3;
        if (!fl && ordy && mq2.size() == 0 && mb2 != 16'hFFFF) mb2 = mb2 + 16'd1;
        if (!fl && ordy && mq3.size() == 0 && mb3 != 16'hFFFF) mb3 = mb3 + 16'd1;
        if (fl) begin
            mq2.delete();
            mq3.delete();
        end else begin
            pu2 = iv && mq2.size() < 2;
            po2 = ordy && mq2.size() > 0;
            pu3 = iv && mq3.size() < 3;
            po3 = ordy && mq3.size() > 0;
            if (po2) void'(mq2.pop_front());
            if (pu2) mq2.push_back(d);
            if (po3) void'(mq3.pop_front());
            if (pu3) mq3.push_back(d);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        modelStep(fl, iv, d, ordy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".count2"},  32'(count2),     32'(mq2.size()));
        checkVal({tag, ".valid2"},  32'(out_valid2), 32'(mq2.size() != 0));
        checkVal({tag, ".data2"},   32'(out_data2),  (mq2.size() != 0) ? 32'(mq2[0]) : 32'h0);
        checkVal({tag, ".ready2"},  32'(in_ready2),  32'(mq2.size() < 2));
        checkVal({tag, ".bubble2"}, 32'(bubble2),    32'(mb2));
        checkVal({tag, ".count3"},  32'(count3),     32'(mq3.size()));
        checkVal({tag, ".valid3"},  32'(out_valid3), 32'(mq3.size() != 0));
        checkVal({tag, ".data3"},   32'(out_data3),  (mq3.size() != 0) ? 32'(mq3[0]) : 32'h0);
        checkVal({tag, ".ready3"},  32'(in_ready3),  32'(mq3.size() < 3));
        checkVal({tag, ".bubble3"}, 32'(bubble3),    32'(mb3));
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, ".count2"},  32'(count2),     32'h0);
        checkVal({tag, ".valid2"},  32'(out_valid2), 32'h0);
        checkVal({tag, ".data2"},   32'(out_data2),  32'h0);
        checkVal({tag, ".ready2"},  32'(in_ready2),  32'h1);
        checkVal({tag, ".bubble2"}, 32'(bubble2),    32'h0);
        checkVal({tag, ".count3"},  32'(count3),     32'h0);
        checkVal({tag, ".valid3"},  32'(out_valid3), 32'h0);
        checkVal({tag, ".ready3"},  32'(in_ready3),  32'h1);
        checkVal({tag, ".bubble3"}, 32'(bubble3),    32'h0);
    endtask

    initial begin
        // Columns: flush, in_valid, in_data, out_ready -> count, valid, data, ready, bubble (DEPTH=2)
        vecs[0]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 2'd1, 1'b1, 8'hA1, 1'b1, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 2'd2, 1'b1, 8'hA1, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd1, 1'b1, 8'hA2, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, 2'd1, 1'b1, 8'h11, 1'b1, 16'd0};
        vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 1'b1, 8'h11, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b1, 2'd1, 1'b1, 8'h22, 1'b1, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 2'd2, 1'b1, 8'h22, 1'b0, 16'd0};
        vecs[8]  = '{1'b1, 1'b1, 8'h77, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 16'd1};
        vecs[10] = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 8'h33, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 16'd2};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            checkVal($sformatf("vec%0d.count", i),  32'(count2),     32'(vecs[i].cnt));
            checkVal($sformatf("vec%0d.valid", i),  32'(out_valid2), 32'(vecs[i].vld));
            checkVal($sformatf("vec%0d.data", i),   32'(out_data2),  32'(vecs[i].dat));
            checkVal($sformatf("vec%0d.ready", i),  32'(in_ready2),  32'(vecs[i].rdy));
            checkVal($sformatf("vec%0d.bubble", i), 32'(bubble2),    32'(vecs[i].bub));
            checkOutput($sformatf("vec%0d.model", i));
        end

        // Streaming through DEPTH=3 exercises pointer wrap many times over.
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(k), 1'b1);
            checkVal($sformatf("stream%0d.data3", k),  32'(out_data3), 32'(k));
            checkVal($sformatf("stream%0d.count3", k), 32'(count3),    32'd1);
            checkOutput($sformatf("stream%0d", k));
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkVal("stream_end.count3", 32'(count3), 32'd0);
        checkOutput("stream_end");

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom),
                          (n < 200) ? 1'($urandom) : ($urandom_range(0, 3) != 0));
            checkOutput($sformatf("rand%0d", n));
        end

        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 66000; n++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkVal("sat.bubble2", 32'(bubble2), 32'hFFFF);
        checkVal("sat.bubble3", 32'(bubble3), 32'hFFFF);
        checkOutput("sat");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        checkVal("sat_flush.bubble2", 32'(bubble2), 32'hFFFF);
        checkVal("sat_flush.bubble3", 32'(bubble3), 32'hFFFF);
        checkOutput("sat_flush");

        applyStimulus(1'b0, 1'b1, 8'hC1, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hC2, 1'b0);
        checkVal("prerst.count2", 32'(count2), 32'd2);
        checkOutput("prerst");
        #2 rst = 1'b1;
        modelReset();
        #1 checkResetValues("async_rst");
        in_valid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst");
        applyStimulus(1'b0, 1'b1, 8'h99, 1'b0);
        checkVal("post_rst.data2", 32'(out_data2), 32'h99);
        checkVal("post_rst.data3", 32'(out_data3), 32'h99);
        checkOutput("post_rst_push");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkVal("post_rst.valid2", 32'(out_valid2), 32'h0);
        checkOutput("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
